// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Timing bus produced by vga_timing_gen and consumed by the background/draw
// pipeline.
//   active_mode  mode currently being generated (0 = parameterised, 1 = 640x480)
//   hcount       pixel index within the line
//   vcount       line index within the frame
//   hsync/vsync  sync pulses with the active mode's polarity applied
//   hblnk/vblnk  horizontal / vertical blanking
//   frame_start  high while the position is (0,0)
//   frame_cnt    16-bit frame counter, present only with VGA_FRAME_CNT_EN
// Modports: master (generator side drives), slave (consumer side reads).
// Optional feature macro: VGA_FRAME_CNT_EN
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             active_mode;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        output active_mode, hcount, vcount, hsync, vsync,
               hblnk, vblnk, frame_start, frame_cnt
    );
    modport slave (
        input  active_mode, hcount, vcount, hsync, vsync,
               hblnk, vblnk, frame_start, frame_cnt
    );
`else
    modport master (
        output active_mode, hcount, vcount, hsync, vsync,
               hblnk, vblnk, frame_start
    );
    modport slave (
        input  active_mode, hcount, vcount, hsync, vsync,
               hblnk, vblnk, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Programmable VGA timing generator. Produces pixel/line counters, sync and
// blanking for one of two run-time selectable modes:
//   mode 0 : parameterised (800x600@60 at 40 MHz by default)
//   mode 1 : fixed 640x480@60, both syncs active-low
// A mode request is only taken at the last pixel of a frame, so a frame is
// never generated with mixed timing.
// Ports:
//   clk       pixel clock
//   rst_n     synchronous reset, active-low
//   en        count enable; low freezes every register
//   mode_sel  requested mode, sampled at frame end only
//   vid       timing bus (vga_timing_gen_if.master)
// Optional feature macro: VGA_FRAME_CNT_EN adds vid.frame_cnt, a 16-bit
// wrapping count of enabled frame wraps.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CNT_W     = 11,
    parameter int H_ACT     = 800,
    parameter int H_SS      = 840,
    parameter int H_SE      = 968,
    parameter int H_TOT     = 1056,
    parameter int V_ACT     = 600,
    parameter int V_SS      = 601,
    parameter int V_SE      = 605,
    parameter int V_TOT     = 628,
    parameter bit SYNC_POS0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_sel,
    vga_timing_gen_if.master vid
);

    localparam int NMODES = 2;

    // Per-mode timing tables, index = mode number.
    localparam logic [CNT_W-1:0] H_ACT_T [NMODES] = '{CNT_W'(H_ACT), CNT_W'(640)};
    localparam logic [CNT_W-1:0] H_SS_T  [NMODES] = '{CNT_W'(H_SS),  CNT_W'(656)};
    localparam logic [CNT_W-1:0] H_SE_T  [NMODES] = '{CNT_W'(H_SE),  CNT_W'(752)};
    localparam logic [CNT_W-1:0] H_TOT_T [NMODES] = '{CNT_W'(H_TOT), CNT_W'(800)};
    localparam logic [CNT_W-1:0] V_ACT_T [NMODES] = '{CNT_W'(V_ACT), CNT_W'(480)};
    localparam logic [CNT_W-1:0] V_SS_T  [NMODES] = '{CNT_W'(V_SS),  CNT_W'(490)};
    localparam logic [CNT_W-1:0] V_SE_T  [NMODES] = '{CNT_W'(V_SE),  CNT_W'(492)};
    localparam logic [CNT_W-1:0] V_TOT_T [NMODES] = '{CNT_W'(V_TOT), CNT_W'(525)};
    localparam bit               SYNC_T  [NMODES] = '{SYNC_POS0,     1'b0};

    logic [CNT_W-1:0] hcount_reg, hcount_next;
    logic [CNT_W-1:0] vcount_reg, vcount_next;
    logic             mode_reg, mode_next;
    logic             hsync_reg, vsync_reg;
    logic             hblnk_reg, vblnk_reg;
    logic             frame_start_reg;
    logic             line_end, frame_end;

    // Decoded candidates for every mode, evaluated on the next-count values.
    logic [NMODES-1:0] hsync_cand, vsync_cand, hblnk_cand, vblnk_cand;

    // Next-position logic. Wrap limits come from the mode in force for the
    // current frame; ">=" keeps the counters bounded even if a count were ever
    // left beyond the limit.
    always_comb begin
        line_end    = (hcount_reg >= H_TOT_T[mode_reg] - CNT_W'(1));
        frame_end   = line_end && (vcount_reg >= V_TOT_T[mode_reg] - CNT_W'(1));
        hcount_next = hcount_reg + CNT_W'(1);
        vcount_next = vcount_reg;
        mode_next   = mode_reg;
        if (line_end) begin
            hcount_next = '0;
            if (frame_end) begin
                vcount_next = '0;
                mode_next   = mode_sel;
            end else begin
                vcount_next = vcount_reg + CNT_W'(1);
            end
        end
    end

    // Sync compare results are XNOR-ed with the mode polarity so that an
    // active-low mode idles high.
    for (genvar gi = 0; gi < NMODES; gi++) begin : g_mode_decode
        assign hblnk_cand[gi] = (hcount_next >= H_ACT_T[gi]);
        assign vblnk_cand[gi] = (vcount_next >= V_ACT_T[gi]);
        assign hsync_cand[gi] = ((hcount_next >= H_SS_T[gi]) &&
                                 (hcount_next <  H_SE_T[gi])) == SYNC_T[gi];
        assign vsync_cand[gi] = ((vcount_next >= V_SS_T[gi]) &&
                                 (vcount_next <  V_SE_T[gi])) == SYNC_T[gi];
    end

    // Decoding the next values, selected by the next mode, keeps every output
    // aligned with the counters, including the first cycle after a mode change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            mode_reg        <= 1'b0;
            hsync_reg       <= !SYNC_POS0;
            vsync_reg       <= !SYNC_POS0;
            hblnk_reg       <= 1'b0;
            vblnk_reg       <= 1'b0;
            frame_start_reg <= 1'b1;
        end else if (en) begin
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            mode_reg        <= mode_next;
            hsync_reg       <= hsync_cand[mode_next];
            vsync_reg       <= vsync_cand[mode_next];
            hblnk_reg       <= hblnk_cand[mode_next];
            vblnk_reg       <= vblnk_cand[mode_next];
            frame_start_reg <= (hcount_next == '0) && (vcount_next == '0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (en && frame_end) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_reg;
`endif

    assign vid.active_mode = mode_reg;
    assign vid.hcount      = hcount_reg;
    assign vid.vcount      = vcount_reg;
    assign vid.hsync       = hsync_reg;
    assign vid.vsync       = vsync_reg;
    assign vid.hblnk       = hblnk_reg;
    assign vid.vblnk       = vblnk_reg;
    assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Mode 0 is shrunk to a 20x10 frame
// so that frame wraps and mode switches happen quickly; mode 1 keeps its
// fixed 640x480 timing. The reference model tracks the linear position
// inside the frame and derives line/pixel, sync and blanking arithmetically.
// Optional feature macro: VGA_FRAME_CNT_EN (frame counter checks).
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CNT_W = 11;
    localparam int HA = 12, HS = 14, HE = 17, HT = 20;
    localparam int VA = 6,  VS = 7,  VE = 8,  VT = 10;

    localparam int K_HA = 0, K_HS = 1, K_HE = 2, K_HT = 3;
    localparam int K_VA = 4, K_VS = 5, K_VE = 6, K_VT = 7;
    localparam int M0 [8] = '{HA, HS, HE, HT, VA, VS, VE, VT};
    localparam int M1 [8] = '{640, 656, 752, 800, 480, 490, 492, 525};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic mode_sel = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    vga_timing_gen_if #(.CNT_W(CNT_W)) vid ();

    vga_timing_gen #(
        .CNT_W(CNT_W), .H_ACT(HA), .H_SS(HS), .H_SE(HE), .H_TOT(HT),
        .V_ACT(VA), .V_SS(VS), .V_SE(VE), .V_TOT(VT), .SYNC_POS0(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode_sel(mode_sel),
        .vid(vid)
    );

    always #5 clk = ~clk;

    function automatic int mc(input bit m, input int k);
        return m ? M1[k] : M0[k];
    endfunction

    // Reference model: linear position within the frame plus frame mode.
    int m_pos = 0;
    bit m_mode = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos  <= 0;
            m_mode <= 1'b0;
        end else if (en) begin
            if (m_pos == mc(m_mode, K_HT) * mc(m_mode, K_VT) - 1) begin
                m_pos  <= 0;
                m_mode <= mode_sel;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            int h, v;
            bit pos, in_h, in_v;
            h    = m_pos % mc(m_mode, K_HT);
            v    = m_pos / mc(m_mode, K_HT);
            pos  = (m_mode == 1'b0);
            in_h = (h >= mc(m_mode, K_HS)) && (h < mc(m_mode, K_HE));
            in_v = (v >= mc(m_mode, K_VS)) && (v < mc(m_mode, K_VE));
            check("hcount", 32'(vid.hcount), h);
            check("vcount", 32'(vid.vcount), v);
            check("active_mode", 32'(vid.active_mode), 32'(m_mode));
            check("hsync", 32'(vid.hsync), 32'(pos ? in_h : !in_h));
            check("vsync", 32'(vid.vsync), 32'(pos ? in_v : !in_v));
            check("hblnk", 32'(vid.hblnk), 32'(h >= mc(m_mode, K_HA)));
            check("vblnk", 32'(vid.vblnk), 32'(v >= mc(m_mode, K_VA)));
            check("frame_start", 32'(vid.frame_start), 32'(m_pos == 0));
        end
    end

    // Drive one cycle's inputs, then return on the following falling edge.
    task automatic tick(input bit r, input bit e, input bit ms);
        rst_n    = r;
        en       = e;
        mode_sel = ms;
        @(negedge clk);
    endtask

    // Count with en=1 until the model reaches a frame position (bounded).
    task automatic run_to(input int target, input bit rnd_ms, input bit ms_fix, input string tag);
        int n;
        n = 0;
        while (m_pos != target && n < 5000) begin
            tick(1'b1, 1'b1, rnd_ms ? 1'($urandom_range(0, 1)) : ms_fix);
            n++;
        end
        total++;
        if (m_pos != target) begin
            bad++;
            $display("FAIL %s: position %0d not reached, stuck at %0d", tag, target, m_pos);
        end
    endtask

    initial begin
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk_on = 1'b1;

        // Reset state, hand-computed.
        check("rst_hcount", 32'(vid.hcount), 0);
        check("rst_vcount", 32'(vid.vcount), 0);
        check("rst_mode", 32'(vid.active_mode), 0);
        check("rst_hsync", 32'(vid.hsync), 0);
        check("rst_vsync", 32'(vid.vsync), 0);
        check("rst_hblnk", 32'(vid.hblnk), 0);
        check("rst_vblnk", 32'(vid.vblnk), 0);
        check("rst_frame_start", 32'(vid.frame_start), 1);

        // Line timing in mode 0: sync start, sync end, line wrap.
        repeat (14) tick(1'b1, 1'b1, 1'b0);
        check("m0_h14_hcount", 32'(vid.hcount), 14);
        check("m0_h14_hsync", 32'(vid.hsync), 1);
        check("m0_h14_hblnk", 32'(vid.hblnk), 1);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        check("m0_h16_hsync", 32'(vid.hsync), 1);
        tick(1'b1, 1'b1, 1'b0);
        check("m0_h17_hsync", 32'(vid.hsync), 0);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        check("m0_h19_hcount", 32'(vid.hcount), 19);
        tick(1'b1, 1'b1, 1'b0);
        check("m0_wrap_hcount", 32'(vid.hcount), 0);
        check("m0_wrap_vcount", 32'(vid.vcount), 1);
        check("m0_wrap_hblnk", 32'(vid.hblnk), 0);

        // Random enable / mid-frame mode toggles / reset pulses, mode 0 kept.
        for (int i = 0; i < 900; i++) begin
            bit ms;
            ms = 1'($urandom_range(0, 1));
            if (m_pos == HT * VT - 1) ms = 1'b0;
            tick(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 4) != 0), ms);
        end
        check("rand_mode_still0", 32'(vid.active_mode), 0);

        // Mode request mid-frame, honoured only at frame end.
        run_to(3 * HT, 1'b0, 1'b0, "reach_v3");
        run_to(HT * VT - 1, 1'b1, 1'b0, "reach_frame_end");
        check("pre_switch_mode", 32'(vid.active_mode), 0);
        repeat (10) tick(1'b1, 1'b0, 1'b1);
        check("hold_hcount", 32'(vid.hcount), 19);
        check("hold_vcount", 32'(vid.vcount), 9);
        check("hold_mode", 32'(vid.active_mode), 0);
        check("hold_frame_start", 32'(vid.frame_start), 0);
        tick(1'b1, 1'b1, 1'b1);
        check("sw_hcount", 32'(vid.hcount), 0);
        check("sw_vcount", 32'(vid.vcount), 0);
        check("sw_mode", 32'(vid.active_mode), 1);
        check("sw_frame_start", 32'(vid.frame_start), 1);
        check("sw_hsync_idle_high", 32'(vid.hsync), 1);
        check("sw_vsync_idle_high", 32'(vid.vsync), 1);

        // Mode 1 hsync window 656..751, active-low.
        run_to(655, 1'b1, 1'b0, "reach_m1_655");
        check("m1_h655_hsync", 32'(vid.hsync), 1);
        tick(1'b1, 1'b1, 1'b0);
        check("m1_h656_hsync", 32'(vid.hsync), 0);
        run_to(751, 1'b1, 1'b0, "reach_m1_751");
        check("m1_h751_hsync", 32'(vid.hsync), 0);
        tick(1'b1, 1'b1, 1'b0);
        check("m1_h752_hsync", 32'(vid.hsync), 1);
        check("m1_h752_hblnk", 32'(vid.hblnk), 1);

        for (int i = 0; i < 2500; i++)
            tick(1'b1, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));

        // Reset mid-line in mode 1.
        run_to((m_pos / 800 + 1) * 800 + 500, 1'b1, 1'b0, "reach_m1_500");
        check("m1_pre_rst_hcount", 32'(vid.hcount), 500);
        check("m1_pre_rst_mode", 32'(vid.active_mode), 1);
        tick(1'b0, 1'b1, 1'b1);
        check("m1_rst_hcount", 32'(vid.hcount), 0);
        check("m1_rst_vcount", 32'(vid.vcount), 0);
        check("m1_rst_mode", 32'(vid.active_mode), 0);
        check("m1_rst_hsync", 32'(vid.hsync), 0);
        check("m1_rst_vsync", 32'(vid.vsync), 0);
        check("m1_rst_frame_start", 32'(vid.frame_start), 1);

        // Long mixed random run.
        for (int i = 0; i < 50000; i++)
            tick(1'($urandom_range(0, 2999) != 0), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 1)));

`ifdef VGA_FRAME_CNT_EN
        tick(1'b0, 1'b0, 1'b0);
        check("fcnt_rst", 32'(vid.frame_cnt), 0);
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        check("fcnt_preload", 32'(vid.frame_cnt), 32'h0000FFFF);
        run_to(HT * VT - 1, 1'b0, 1'b0, "fcnt_frame_end");
        check("fcnt_before_wrap", 32'(vid.frame_cnt), 32'h0000FFFF);
        tick(1'b1, 1'b1, 1'b0);
        check("fcnt_wrap", 32'(vid.frame_cnt), 0);
`endif

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
